logic_unit_pipe: RTL and testbench

//  Parametrised, registered bitwise logic unit with valid/ready handshake on both sides.

---
 rtl/logic_unit_pipe.sv | 92 +++++++++
 tb/tb_logic_unit_pipe.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready handshake on both sides.
// Optional out_parity port is enabled by defining LOGIC_UNIT_PARITY_EN.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_zero,
`ifdef LOGIC_UNIT_PARITY_EN
  output logic             out_parity,
`endif
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NOTA = 3'b011,
    OP_NAND = 3'b100,
    OP_NOR  = 3'b101,
    OP_XNOR = 3'b110,
    OP_B    = 3'b111
  } op_e;

  op_e              op_sel;
  logic [WIDTH-1:0] op_res;
  logic             accept;
  logic             xfer;

  assign op_sel   = op_e'(op);
  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  always_comb begin
    op_res = '0;
    case (op_sel)
      OP_AND:  op_res = a & b;
      OP_OR:   op_res = a | b;
      OP_XOR:  op_res = a ^ b;
      OP_NOTA: op_res = ~a;
      OP_NAND: op_res = ~(a & b);
      OP_NOR:  op_res = ~(a | b);
      OP_XNOR: op_res = ~(a ^ b);
      OP_B:    op_res = b;
      default: op_res = '0;
    endcase
  end

  // A new accept takes priority over the transfer so a simultaneous
  // accept and transfer keeps out_valid high with the fresh result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      out_zero  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= op_res;
      out_zero  <= (op_res == '0);
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      done_cnt <= '0;
    else if (xfer)
      done_cnt <= done_cnt + 1'b1;
  end

`ifdef LOGIC_UNIT_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)
      out_parity <= 1'b0;
    else if (accept)
      out_parity <= ^op_res;
  end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed table-driven bench for logic_unit_pipe (WIDTH=8, CNT_W=4).
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       out_zero;
  logic [3:0] done_cnt;
`ifdef LOGIC_UNIT_PARITY_EN
  logic       out_parity;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_zero  (out_zero),
`ifdef LOGIC_UNIT_PARITY_EN
    .out_parity(out_parity),
`endif
    .done_cnt  (done_cnt)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       zero;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    vecs[0] = '{3'b000, 8'hC5, 8'h3A, 8'h00, 1'b1};
    vecs[1] = '{3'b001, 8'hC5, 8'h3A, 8'hFF, 1'b0};
    vecs[2] = '{3'b010, 8'hC5, 8'h3A, 8'hFF, 1'b0};
    vecs[3] = '{3'b011, 8'hC5, 8'h3A, 8'h3A, 1'b0};
    vecs[4] = '{3'b100, 8'hC5, 8'h3A, 8'hFF, 1'b0};
    vecs[5] = '{3'b101, 8'hC5, 8'h3A, 8'h00, 1'b1};
    vecs[6] = '{3'b110, 8'hC5, 8'h3A, 8'h00, 1'b1};
    vecs[7] = '{3'b111, 8'hC5, 8'h3A, 8'h3A, 1'b0};
    vecs[8] = '{3'b010, 8'hAA, 8'h55, 8'hFF, 1'b0};
    vecs[9] = '{3'b110, 8'h5A, 8'hA5, 8'h00, 1'b1};

    // Reset with in_valid held high: nothing may be accepted.
    rst = 1'b1; in_valid = 1'b1; a = 8'hC5; b = 8'h3A; op = 3'b001; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", 32'(result), 32'h00);
      chk("rst_out_zero", 32'(out_zero), 32'd0);
      chk("rst_done_cnt", 32'(done_cnt), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
    end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    // All ops back to back, one per cycle.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      @(negedge clk);
      chk("op_out_valid", 32'(out_valid), 32'd1);
      chk("op_result", 32'(result), 32'(vecs[i].res));
      chk("op_zero", 32'(out_zero), 32'(vecs[i].zero));
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_result_hold", 32'(result), 32'h00);
    chk("drain_done_cnt", 32'(done_cnt), 32'd10);

    // Backpressure.
    in_valid = 1'b1; a = 8'h0F; b = 8'hF0; op = 3'b001; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_result", 32'(result), 32'hFF);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_done_cnt", 32'(done_cnt), 32'd10);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_done_cnt", 32'(done_cnt), 32'd11);
    @(negedge clk);
    chk("release_single", 32'(done_cnt), 32'd11);

    // 20 back-to-back transfers from a zeroed counter; wraps 15->0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    op = 3'b001; b = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = 8'(i + 1);
      @(negedge clk);
      chk("b2b_out_valid", 32'(out_valid), 32'd1);
      chk("b2b_result", 32'(result), 32'(i + 1));
      chk("b2b_done_cnt", 32'(done_cnt), 32'(i % 16));
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_final_cnt", 32'(done_cnt), 32'd4);
    chk("b2b_final_valid", 32'(out_valid), 32'd0);

    // Reset while a result is stalled.
    in_valid = 1'b1; a = 8'h00; op = 3'b011; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_stall_valid", 32'(out_valid), 32'd1);
    chk("mid_stall_result", 32'(result), 32'hFF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_cnt", 32'(done_cnt), 32'd0);
    chk("mid_rst_result", 32'(result), 32'h00);
    @(negedge clk);
    chk("mid_rst_no_xfer", 32'(done_cnt), 32'd0);
    chk("mid_rst_still_idle", 32'(out_valid), 32'd0);

`ifdef LOGIC_UNIT_PARITY_EN
    in_valid = 1'b1; a = 8'h07; b = 8'h00; op = 3'b001;
    @(negedge clk);
    chk("par_result", 32'(result), 32'h07);
    chk("par_odd", 32'(out_parity), 32'd1);
    b = 8'h03; op = 3'b111;
    @(negedge clk);
    in_valid = 1'b0;
    chk("par_result2", 32'(result), 32'h03);
    chk("par_even", 32'(out_parity), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
